// File: rtl/sc_io_ports.sv
// Memory-mapped I/O unit: synchronised, debounced input ports with LED mirror,
// writable output ports, sticky change status and a maskable interrupt.
module sc_io_ports #(
  parameter int N_IN         = 2,
  parameter int N_OUT        = 3,
  parameter int DW           = 32,
  parameter int LED_BITS     = 5,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [7:0]               addr,
  input  logic [DW-1:0]            wdata,
  input  logic                     we,
  input  logic                     re,
  output logic [DW-1:0]            rdata,
  input  logic [N_IN*DW-1:0]       in_port,
  output logic [N_OUT*DW-1:0]      out_port,
  output logic [N_IN*LED_BITS-1:0] led,
  output logic                     irq
);

  localparam int              CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [4:0]      N_IN_W   = 5'(N_IN);
  localparam logic [4:0]      N_OUT_W  = 5'(N_OUT);

  // Bus access: we and re are single-cycle strobes with no handshake; a write
  // takes effect on the edge it is sampled, a read loads rdata on that edge.
  logic [5:0] word;
  logic       in_sel, out_sel, status_sel, irq_en_sel;
  logic       unused_addr_bits;

  assign word             = addr[7:2];
  assign unused_addr_bits = ^addr[1:0];
  assign in_sel           = (word[5:4] == 2'b00) && ({1'b0, word[3:0]} < N_IN_W);
  assign out_sel          = (word[5:4] == 2'b01) && ({1'b0, word[3:0]} < N_OUT_W);
  assign status_sel       = (word == 6'h20);
  assign irq_en_sel       = (word == 6'h21);

  logic [N_IN*DW-1:0] stable_flat;
  logic [N_IN-1:0]    accept;
  logic [N_IN-1:0]    status_q;
  logic [N_IN-1:0]    irq_en_q;
  logic [N_IN-1:0]    w1c_mask;
  logic [DW-1:0]      rd_val;

  // Per-port synchroniser and debouncer.  A change arriving at sync2 restarts
  // the count on the same edge it lands, so acceptance falls on edge 2+DEBOUNCE_CYC.
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    logic [DW-1:0]       s1, s2, stab;
    logic [CW-1:0]       cnt;
    logic [LED_BITS-1:0] led_q;
    logic                restart;

    assign restart   = (s1 != s2) || (s2 == stab);
    assign accept[i] = !restart && (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        s1    <= '0;
        s2    <= '0;
        stab  <= '0;
        cnt   <= '0;
        led_q <= '0;
      end else begin
        s1 <= in_port[i*DW +: DW];
        s2 <= s1;
        if (restart) begin
          cnt <= '0;
        end else if (accept[i]) begin
          stab  <= s2;
          led_q <= s2[LED_BITS-1:0];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign stable_flat[i*DW +: DW]      = stab;
    assign led[i*LED_BITS +: LED_BITS]  = led_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_port <= '0;
    end else if (we && out_sel) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (word[3:0] == 4'(j)) out_port[j*DW +: DW] <= wdata;
      end
    end
  end

  assign w1c_mask = (we && status_sel) ? wdata[N_IN-1:0] : '0;

  // A bit accepted on the same edge as its W1C stays set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      status_q <= '0;
      irq_en_q <= '0;
      irq      <= 1'b0;
    end else begin
      status_q <= (status_q & ~w1c_mask) | accept;
      if (we && irq_en_sel) irq_en_q <= wdata[N_IN-1:0];
      irq <= |(status_q & irq_en_q);
    end
  end

  always_comb begin
    rd_val = '0;
    if (in_sel) begin
      for (int i = 0; i < N_IN; i++) begin
        if (word[3:0] == 4'(i)) rd_val = stable_flat[i*DW +: DW];
      end
    end
    if (out_sel) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (word[3:0] == 4'(j)) rd_val = out_port[j*DW +: DW];
      end
    end
    if (status_sel) rd_val = DW'(status_q);
    if (irq_en_sel) rd_val = DW'(irq_en_q);
  end

  // rdata samples pre-write state, so a same-cycle read/write returns the old value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_sc_io_ports.sv
// Self-checking bench for sc_io_ports with default parameters; read data is
// checked through an expected-value queue, pin-level outputs inline.
module tb_sc_io_ports;
  localparam int N_IN = 2, N_OUT = 3, DW = 32, LED_BITS = 5, DEB = 4;

  logic                     clock = 1'b0;
  logic                     resetn = 1'b0;
  logic [7:0]               addr = '0;
  logic [DW-1:0]            wdata = '0;
  logic                     we = 1'b0;
  logic                     re = 1'b0;
  logic [DW-1:0]            rdata;
  logic [N_IN*DW-1:0]       in_port = '0;
  logic [N_OUT*DW-1:0]      out_port;
  logic [N_IN*LED_BITS-1:0] led;
  logic                     irq;

  int                  vectors = 0;
  int                  miscompares = 0;
  logic [DW-1:0]       exp_q[$];
  logic [DW-1:0]       rd_exp;
  logic                rd_due = 1'b0;
  logic [N_OUT*DW-1:0] out_m = '0;

  sc_io_ports #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .LED_BITS(LED_BITS), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .in_port(in_port), .out_port(out_port), .led(led), .irq(irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard for read data ----------------
  always @(posedge clock) rd_due <= resetn && re;

  always @(negedge clock) begin
    if (rd_due) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rdata_unexpected: got %h, expected no read", rdata);
      end else begin
        rd_exp = exp_q.pop_front();
        if (rdata !== rd_exp) begin
          miscompares++;
          $display("FAIL rdata: got %h, expected %h", rdata, rd_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus(input logic [7:0] a, input logic [DW-1:0] d,
                     input logic w, input logic r, input logic [DW-1:0] e);
    addr = a; wdata = d; we = w; re = r;
    if (r) exp_q.push_back(e);
    @(negedge clock);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [DW-1:0] d);
    bus(a, d, 1'b1, 1'b0, '0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [DW-1:0] e);
    bus(a, '0, 1'b0, 1'b1, e);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    resetn = 1'b0;
    in_port = {32'h0, 32'h1F};
    tick(2);
    vectors++;
    if (led !== '0 || out_port !== '0 || irq !== 1'b0 || rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got led=%h out=%h irq=%b rdata=%h, expected all 0",
               led, out_port, irq, rdata);
    end
    resetn = 1'b1;
    tick(5);
    vectors++;
    if (led !== 10'h000) begin
      miscompares++;
      $display("FAIL reset_led_early: got %h, expected %h", led, 10'h000);
    end
    tick(1);
    vectors++;
    if (led !== 10'h01F) begin
      miscompares++;
      $display("FAIL reset_led_edge6: got %h, expected %h", led, 10'h01F);
    end
    rd(8'h00, 32'h1F);
    rd(8'h80, 32'h1);
    wr(8'h80, 32'h1);
    rd(8'h80, 32'h0);
  endtask

  task automatic test_debounce;
    in_port[31:0] = 32'h0A;
    for (int k = 1; k < 6; k++) begin
      tick(1);
      vectors++;
      if (led !== 10'h01F) begin
        miscompares++;
        $display("FAIL debounce_early edge %0d: got %h, expected %h", k, led, 10'h01F);
      end
    end
    tick(1);
    vectors++;
    if (led !== 10'h00A || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL debounce_edge6: got led=%h irq=%b, expected led=%h irq=0", led, irq, 10'h00A);
    end
    rd(8'h80, 32'h1);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL debounce_irq_masked: got %b, expected 0", irq);
    end
    wr(8'h80, 32'h1);
  endtask

  task automatic test_glitch;
    int b, len;
    for (int rep = 0; rep < 3; rep++) begin
      b   = $urandom_range(0, LED_BITS - 1);
      len = $urandom_range(1, DEB - 1);
      in_port[DW + b] = 1'b1;
      tick(len);
      in_port[DW + b] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick(1);
        vectors++;
        if (led !== 10'h00A) begin
          miscompares++;
          $display("FAIL glitch_led bit %0d len %0d: got %h, expected %h", b, len, led, 10'h00A);
        end
      end
    end
    rd(8'h04, 32'h0);
    rd(8'h80, 32'h0);
  endtask

  task automatic test_out_rw;
    int j;
    logic [DW-1:0] d;
    logic [7:0] a;
    wr(8'h48, 32'hDEADBEEF);
    out_m[95:64] = 32'hDEADBEEF;
    vectors++;
    if (out_port !== out_m) begin
      miscompares++;
      $display("FAIL out2_write: got %h, expected %h", out_port, out_m);
    end
    rd(8'h48, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      j = $urandom_range(0, 1);
      d = $urandom();
      a = 8'(64 + 4 * j);
      wr(a, d);
      out_m[j*DW +: DW] = d;
      vectors++;
      if (out_port !== out_m) begin
        miscompares++;
        $display("FAIL out_write port %0d: got %h, expected %h", j, out_port, out_m);
      end
      rd(a, d);
    end
    d = $urandom();
    bus(8'h40, d, 1'b1, 1'b1, out_m[31:0]);
    out_m[31:0] = d;
    vectors++;
    if (out_port !== out_m) begin
      miscompares++;
      $display("FAIL out_same_cycle_rw: got %h, expected %h", out_port, out_m);
    end
    rd(8'h40, d);
  endtask

  task automatic test_irq_w1c;
    wr(8'h84, 32'h2);
    rd(8'h84, 32'h2);
    in_port[63:32] = 32'h3;
    tick(6);
    vectors++;
    if (led !== 10'h06A || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_accept_edge: got led=%h irq=%b, expected led=%h irq=0", led, irq, 10'h06A);
    end
    tick(1);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise: got %b, expected 1", irq);
    end
    rd(8'h80, 32'h2);
    wr(8'h80, 32'h2);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_hold_after_w1c: got %b, expected 1", irq);
    end
    tick(1);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_fall: got %b, expected 0", irq);
    end
    rd(8'h80, 32'h0);
    in_port[63:32] = 32'h5;
    tick(5);
    wr(8'h80, 32'h2);
    rd(8'h80, 32'h2);
    vectors++;
    if (irq !== 1'b1 || led !== 10'h0AA) begin
      miscompares++;
      $display("FAIL set_wins_w1c: got irq=%b led=%h, expected irq=1 led=%h", irq, led, 10'h0AA);
    end
    wr(8'h80, 32'h3);
    tick(1);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear: got %b, expected 0", irq);
    end
  endtask

  task automatic test_unmapped_reset;
    rd(8'hFC, 32'h0);
    rd(8'h08, 32'h0);
    rd(8'h4C, 32'h0);
    rd(8'h88, 32'h0);
    wr(8'h10, 32'hFFFFFFFF);
    wr(8'h00, 32'hFFFFFFFF);
    wr(8'h4C, 32'hFFFFFFFF);
    wr(8'h88, 32'hFFFFFFFF);
    wr(8'hFC, 32'hFFFFFFFF);
    vectors++;
    if (out_port !== out_m || led !== 10'h0AA || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL unmapped_write: got out=%h led=%h irq=%b, expected out=%h led=%h irq=0",
               out_port, led, irq, out_m, 10'h0AA);
    end
    rd(8'h00, 32'h0A);
    rd(8'h04, 32'h5);
    rd(8'h84, 32'h2);
    rd(8'h80, 32'h0);
    in_port[31:0] = 32'h15;
    tick(4);
    resetn = 1'b0;
    #1;
    out_m = '0;
    vectors++;
    if (led !== '0 || out_port !== '0 || irq !== 1'b0 || rdata !== '0) begin
      miscompares++;
      $display("FAIL midreset_async: got led=%h out=%h irq=%b rdata=%h, expected all 0",
               led, out_port, irq, rdata);
    end
    tick(1);
    resetn = 1'b1;
    rd(8'h80, 32'h0);
    rd(8'h84, 32'h0);
    tick(3);
    vectors++;
    if (led !== 10'h000) begin
      miscompares++;
      $display("FAIL midreset_led_early: got %h, expected %h", led, 10'h000);
    end
    tick(1);
    vectors++;
    if (led !== 10'h0B5) begin
      miscompares++;
      $display("FAIL midreset_led_edge6: got %h, expected %h", led, 10'h0B5);
    end
    rd(8'h80, 32'h3);
    rd(8'h00, 32'h15);
    vectors++;
    if (out_port !== out_m) begin
      miscompares++;
      $display("FAIL midreset_out: got %h, expected %h", out_port, out_m);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_debounce;
    test_glitch;
    test_out_rw;
    test_irq_w1c;
    test_unmapped_reset;
    tick(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
